// File: rtl/peridot_csr_swi_mbx_pkg.sv
// peridot_csr_swi_mbx_pkg: register map and bit positions shared by the CSR/mailbox block
package peridot_csr_swi_mbx_pkg;
  typedef enum logic [2:0] {
    A_CLASSID,
    A_TIMECODE,
    A_CTRL,
    A_SWI_SET,
    A_SWI_CLR,
    A_SWI_MASK,
    A_MBX_DATA,
    A_MBX_STAT
  } reg_addr_e;
  localparam int unsigned CTRL_RST   = 8;
  localparam int unsigned CTRL_KEY   = 16;
  localparam int unsigned STAT_NIE   = 31;
  localparam int unsigned STAT_FULL  = 30;
  localparam int unsigned STAT_EMPTY = 29;
  localparam int unsigned STAT_OVF   = 28;
  localparam int unsigned STAT_UDF   = 27;
  localparam int unsigned STAT_FLUSH = 16;
endpackage

// File: rtl/peridot_mbx_fifo.sv
// peridot_mbx_fifo: show-ahead register FIFO; flush wins over push, pushes when full and pops when empty are ignored
module peridot_mbx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock_sig,
  input  logic                     reset_sig,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              din_i,
  output logic [31:0]              head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     empty_nx_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic do_push;
  assign level_o = wptr_q - rptr_q;
  assign full_o = level_o == FULL_LVL;
  assign empty_o = wptr_q == rptr_q;
  assign head_o = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign wptr_d = do_push ? wptr_q + ONE : wptr_q;
  assign rptr_d = flush_i ? wptr_q : (pop_i & ~empty_o) ? rptr_q + ONE : rptr_q;
  assign empty_nx_o = wptr_d == rptr_d;
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  // storage is deliberately left unreset; the pointers alone define validity
  always_ff @(posedge clock_sig) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/peridot_csr_swi_mbx.sv
// peridot_csr_swi_mbx: Avalon-MM CSR block with software interrupts, keyed CPU reset,
// LED control and a 32-bit mailbox FIFO with a level interrupt.
module peridot_csr_swi_mbx
  import peridot_csr_swi_mbx_pkg::*;
#(
  parameter int          SWI_CHANNELS  = 4,
  parameter int          MBX_DEPTH     = 16,
  parameter int          LED_WIDTH     = 4,
  parameter logic [31:0] CLASSID       = 32'h72A00000,
  parameter logic [31:0] TIMECODE      = 32'd1234567890,
  parameter logic [15:0] CPURESET_KEY  = 16'hdead,
  parameter bit          CPURESET_INIT = 1'b0
) (
  input  logic                 clock_sig,
  input  logic                 reset_sig,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 ins_irq,
  output logic                 coe_cpureset,
  output logic [LED_WIDTH-1:0] coe_led
);
  localparam int LW = $clog2(MBX_DEPTH);
  reg_addr_e addr;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SWI_CHANNELS-1:0] pend_q, pend_d, mask_q, mask_d;
  logic cpurst_q, cpurst_d, nie_q, nie_d, ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
  logic push, pop_req, flush, full, empty, empty_nx, key_ok, unused;
  logic [31:0] head;
  logic [LW:0] level;
  assign addr = reg_addr_e'(avs_address);
  assign key_ok = CPURESET_KEY == 16'h0 || avs_writedata[CTRL_KEY +: 16] == CPURESET_KEY;
  assign push = avs_write && addr == A_MBX_DATA;
  // a simultaneous write wins, so the pop side effect is dropped
  assign pop_req = avs_read && !avs_write && addr == A_MBX_DATA;
  assign flush = avs_write && addr == A_MBX_STAT && avs_writedata[STAT_FLUSH];
  assign unused = ^avs_writedata;
  assign ins_irq = irq_q;
  assign coe_cpureset = cpurst_q;
  assign coe_led = led_q;
  peridot_mbx_fifo #(.DEPTH(MBX_DEPTH)) u_fifo (
    .clock_sig  (clock_sig),
    .reset_sig  (reset_sig),
    .push_i     (push),
    .pop_i      (pop_req),
    .flush_i    (flush),
    .din_i      (avs_writedata),
    .head_o     (head),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .empty_nx_o (empty_nx)
  );
  always_comb begin
    led_d = led_q;
    cpurst_d = cpurst_q;
    pend_d = pend_q;
    mask_d = mask_q;
    nie_d = nie_q;
    ovf_d = ovf_q | (push & full);
    udf_d = udf_q | (pop_req & empty);
    if (avs_write) begin
      case (addr)
        A_CTRL: begin
          led_d = avs_writedata[LED_WIDTH-1:0];
          cpurst_d = key_ok ? avs_writedata[CTRL_RST] : cpurst_q;
        end
        A_SWI_SET: pend_d = pend_q | avs_writedata[SWI_CHANNELS-1:0];
        A_SWI_CLR: pend_d = pend_q & ~avs_writedata[SWI_CHANNELS-1:0];
        A_SWI_MASK: mask_d = avs_writedata[SWI_CHANNELS-1:0];
        A_MBX_STAT: begin
          nie_d = avs_writedata[STAT_NIE];
          ovf_d = ovf_q & ~avs_writedata[STAT_OVF];
          udf_d = udf_q & ~avs_writedata[STAT_UDF];
        end
        default: ;
      endcase
    end
    // built from next-state values so the irq lands one clock after its cause
    irq_d = |(pend_d & mask_d) | (nie_d & ~empty_nx);
  end
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      led_q <= '0;
      cpurst_q <= CPURESET_INIT;
      pend_q <= '0;
      mask_q <= '0;
      nie_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      led_q <= led_d;
      cpurst_q <= cpurst_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      nie_q <= nie_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      irq_q <= irq_d;
    end
  end
  always_comb begin
    avs_readdata = '0;
    case (addr)
      A_CLASSID: avs_readdata = CLASSID;
      A_TIMECODE: avs_readdata = TIMECODE;
      A_CTRL: begin
        avs_readdata[CTRL_RST] = cpurst_q;
        avs_readdata[LED_WIDTH-1:0] = led_q;
      end
      A_SWI_SET, A_SWI_CLR: avs_readdata[SWI_CHANNELS-1:0] = pend_q;
      A_SWI_MASK: avs_readdata[SWI_CHANNELS-1:0] = mask_q;
      A_MBX_DATA: avs_readdata = empty ? '0 : head;
      A_MBX_STAT: begin
        avs_readdata[STAT_NIE] = nie_q;
        avs_readdata[STAT_FULL] = full;
        avs_readdata[STAT_EMPTY] = empty;
        avs_readdata[STAT_OVF] = ovf_q;
        avs_readdata[STAT_UDF] = udf_q;
        avs_readdata[8:0] = 9'(level);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_peridot_csr_swi_mbx.sv
// tb_peridot_csr_swi_mbx: randomized scenarios against a queue-based model of the CSR/mailbox block;
// a second instance (16 channels, depth 256) covers the large-configuration pointer wrap.
module tb_peridot_csr_swi_mbx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] addr = '0;
  logic rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1, rdata2, rdata;
  logic irq1, irq2, irq, cr1, cr2;
  logic [3:0] led1, led2;
  int compared = 0, mismatched = 0;
  int depth = 16, nch = 4;
  logic [31:0] mq[$];
  bit m_ovf, m_udf, m_nie, m_cr;
  logic [15:0] m_pend, m_mask;
  logic [3:0] m_led;
  always #5 clk = ~clk;
  assign rdata = sel ? rdata2 : rdata1;
  assign irq = sel ? irq2 : irq1;
  peridot_csr_swi_mbx dut (
    .clock_sig(clk), .reset_sig(rst), .avs_address(addr), .avs_read(rd & ~sel), .avs_write(wr & ~sel),
    .avs_writedata(wdata), .avs_readdata(rdata1), .ins_irq(irq1), .coe_cpureset(cr1), .coe_led(led1)
  );
  peridot_csr_swi_mbx #(.SWI_CHANNELS(16), .MBX_DEPTH(256)) dut_big (
    .clock_sig(clk), .reset_sig(rst), .avs_address(addr), .avs_read(rd & sel), .avs_write(wr & sel),
    .avs_writedata(wdata), .avs_readdata(rdata2), .ins_irq(irq2), .coe_cpureset(cr2), .coe_led(led2)
  );

  function automatic logic [15:0] chm();
    return 16'((32'd1 << nch) - 1);
  endfunction
  function automatic logic [31:0] exp_stat();
    int n = mq.size();
    return (32'(m_nie) << 31) | (32'(n == depth) << 30) | (32'(n == 0) << 29) |
           (32'(m_ovf) << 28) | (32'(m_udf) << 27) | 32'(n);
  endfunction
  function automatic logic exp_irq();
    return ((m_pend & m_mask) != 0) || (m_nie && mq.size() != 0);
  endfunction

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    {m_ovf, m_udf, m_nie, m_cr} = '0;
    m_pend = '0; m_mask = '0; m_led = '0;
  endtask
  task automatic push_m(input logic [31:0] d);
    bus_wr(3'd6, d);
    if (mq.size() < depth) mq.push_back(d);
    else m_ovf = 1'b1;
  endtask
  task automatic pop_m(output logic [31:0] got, output logic [31:0] exp);
    bus_rd(3'd6, got);
    if (mq.size() == 0) begin exp = '0; m_udf = 1'b1; end
    else exp = mq.pop_front();
  endtask
  task automatic stat_wr(input logic [31:0] d);
    bus_wr(3'd7, d);
    m_nie = d[31];
    if (d[28]) m_ovf = 1'b0;
    if (d[27]) m_udf = 1'b0;
    if (d[16]) mq.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    bus_rd(3'd2, d);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
    bus_rd(3'd0, d);
    compared++; if (d !== 32'h72A00000) begin mismatched++; $display("FAIL classid got=%h exp=%h", d, 32'h72A00000); end
    bus_rd(3'd1, d);
    compared++; if (d !== 32'd1234567890) begin mismatched++; $display("FAIL timecode got=%h exp=%h", d, 32'd1234567890); end
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat()) begin mismatched++; $display("FAIL reset_stat got=%h exp=%h", d, exp_stat()); end
    compared++; if ({irq1, cr1, led1} !== 6'b0) begin mismatched++; $display("FAIL reset_outs got=%b exp=0", {irq1, cr1, led1}); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d, w;
    bus_wr(3'd2, 32'h0000_0105);
    compared++; if ({cr1, led1} !== 5'b0_0101) begin mismatched++; $display("FAIL ctrl_nokey got=%b exp=00101", {cr1, led1}); end
    bus_wr(3'd2, 32'hDEAD_0100);
    compared++; if ({cr1, led1} !== 5'b1_0000) begin mismatched++; $display("FAIL ctrl_key got=%b exp=10000", {cr1, led1}); end
    m_cr = 1'b1; m_led = 4'h0;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      if (i % 2 == 0) w[31:16] = 16'hdead;
      bus_wr(3'd2, w);
      if (w[31:16] == 16'hdead) m_cr = w[8];
      m_led = w[3:0];
      bus_rd(3'd2, d);
      compared++; if (d !== (32'(m_cr) * 256 + 32'(m_led))) begin mismatched++; $display("FAIL ctrl_rand got=%h exp=%h", d, 32'(m_cr) * 256 + 32'(m_led)); end
      compared++; if ({cr1, led1} !== {m_cr, m_led}) begin mismatched++; $display("FAIL ctrl_pins got=%b exp=%b", {cr1, led1}, {m_cr, m_led}); end
    end
  endtask

  task automatic test_swi();
    logic [31:0] d, w;
    int op;
    bus_wr(3'd5, 32'h3); m_mask = 16'h3;
    bus_wr(3'd3, 32'h2); m_pend = 16'h2;
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL swi_irq_set got=%b exp=1", irq); end
    bus_rd(3'd3, d);
    compared++; if (d !== 32'h2) begin mismatched++; $display("FAIL swi_pending got=%h exp=2", d); end
    bus_wr(3'd4, 32'h2); m_pend = 16'h0;
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL swi_irq_clr got=%b exp=0", irq); end
    bus_rd(3'd4, d);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL swi_cleared got=%h exp=0", d); end
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      w = $urandom;
      bus_wr(3'(3 + op), w);
      if (op == 0) m_pend = m_pend | (w[15:0] & chm());
      else if (op == 1) m_pend = m_pend & ~w[15:0];
      else m_mask = w[15:0] & chm();
      compared++; if (irq !== exp_irq()) begin mismatched++; $display("FAIL swi_rand_irq got=%b exp=%b", irq, exp_irq()); end
      bus_rd(3'd3, d);
      compared++; if (d !== 32'(m_pend)) begin mismatched++; $display("FAIL swi_rand_pend got=%h exp=%h", d, m_pend); end
      bus_rd(3'd5, d);
      compared++; if (d !== 32'(m_mask)) begin mismatched++; $display("FAIL swi_rand_mask got=%h exp=%h", d, m_mask); end
    end
    bus_wr(3'd4, 32'hFFFF_FFFF); m_pend = '0;
  endtask

  task automatic test_fifo_full();
    logic [31:0] d, g, e;
    for (int i = 0; i < 16; i++) push_m(32'(i));
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[30] !== 1'b1 || d[8:0] !== 9'd16) begin mismatched++; $display("FAIL fifo_full got=%h exp=%h", d, exp_stat()); end
    push_m(32'hAA);
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[28] !== 1'b1) begin mismatched++; $display("FAIL fifo_ovf got=%h exp=%h", d, exp_stat()); end
    for (int i = 0; i < 16; i++) begin
      pop_m(g, e);
      compared++; if (g !== e || g !== 32'(i)) begin mismatched++; $display("FAIL fifo_order got=%h exp=%h", g, i); end
    end
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[29] !== 1'b1) begin mismatched++; $display("FAIL fifo_drained got=%h exp=%h", d, exp_stat()); end
    stat_wr(32'h1000_0000);
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat()) begin mismatched++; $display("FAIL ovf_clear got=%h exp=%h", d, exp_stat()); end
  endtask

  task automatic test_udf();
    logic [31:0] d, g, e;
    pop_m(g, e);
    compared++; if (g !== 32'h0) begin mismatched++; $display("FAIL udf_data got=%h exp=0", g); end
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[27] !== 1'b1) begin mismatched++; $display("FAIL udf_set got=%h exp=%h", d, exp_stat()); end
    stat_wr(32'h0800_0000);
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[27] !== 1'b0) begin mismatched++; $display("FAIL udf_clear got=%h exp=%h", d, exp_stat()); end
  endtask

  task automatic test_nempty_irq();
    logic [31:0] d;
    stat_wr(32'h8000_0000);
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL nie_empty got=%b exp=0", irq); end
    push_m(32'h1234_5678);
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL nie_push got=%b exp=1", irq); end
    stat_wr(32'h8001_0000);
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL nie_flush got=%b exp=0", irq); end
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[8:0] !== 9'd0) begin mismatched++; $display("FAIL flush_level got=%h exp=%h", d, exp_stat()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, g, e, w;
    w = $urandom;
    @(negedge clk);
    addr = 3'd6; wdata = w; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    mq.push_back(w);
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat()) begin mismatched++; $display("FAIL rw_collision got=%h exp=%h", d, exp_stat()); end
    pop_m(g, e);
    compared++; if (g !== e) begin mismatched++; $display("FAIL rw_collision_data got=%h exp=%h", g, e); end
  endtask

  task automatic test_random_fifo();
    logic [31:0] d, g, e, w;
    int op;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 7);
      if (op < 3) push_m($urandom);
      else if (op < 6) begin
        pop_m(g, e);
        compared++; if (g !== e) begin mismatched++; $display("FAIL rand_pop got=%h exp=%h", g, e); end
      end else if (op == 6) begin
        bus_rd(3'd7, d);
        compared++; if (d !== exp_stat()) begin mismatched++; $display("FAIL rand_stat got=%h exp=%h", d, exp_stat()); end
      end else begin
        w = $urandom & 32'h9800_0000;
        w[16] = ($urandom_range(0, 3) == 0);
        stat_wr(w);
      end
      compared++; if (irq !== exp_irq()) begin mismatched++; $display("FAIL rand_irq got=%b exp=%b", irq, exp_irq()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e;
    stat_wr(32'h8000_0000);
    for (int i = 0; i < 3; i++) push_m(32'h100 + 32'(i));
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    @(negedge clk);
    addr = 3'd7;
    #2 rst = 1'b1;
    #1;
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL async_irq got=%b exp=0", irq); end
    compared++; if (rdata !== 32'h2000_0000) begin mismatched++; $display("FAIL async_level got=%h exp=%h", rdata, 32'h2000_0000); end
    do_reset();
    pop_m(g, e);
    compared++; if (g !== e) begin mismatched++; $display("FAIL post_reset_pop got=%h exp=%h", g, e); end
  endtask

  task automatic test_wrap_big();
    logic [31:0] d, g, e;
    do_reset();
    sel = 1'b1; depth = 256; nch = 16;
    bus_wr(3'd3, 32'hFFFF_FFFF);
    bus_rd(3'd3, d);
    compared++; if (d !== 32'h0000_FFFF) begin mismatched++; $display("FAIL big_swi got=%h exp=%h", d, 32'hFFFF); end
    bus_wr(3'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 250; i++) push_m($urandom);
    for (int i = 0; i < 300; i++) begin
      push_m($urandom);
      pop_m(g, e);
      compared++; if (g !== e) begin mismatched++; $display("FAIL wrap_order got=%h exp=%h", g, e); end
    end
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[8:0] !== 9'd250) begin mismatched++; $display("FAIL wrap_level got=%h exp=%h", d, exp_stat()); end
    for (int i = 0; i < 6; i++) push_m($urandom);
    bus_rd(3'd7, d);
    compared++; if (d !== exp_stat() || d[30] !== 1'b1) begin mismatched++; $display("FAIL big_full got=%h exp=%h", d, exp_stat()); end
    sel = 1'b0; depth = 16; nch = 4;
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_swi();
    test_fifo_full();
    test_udf();
    test_nempty_irq();
    test_back_to_back();
    test_random_fifo();
    test_reset_mid();
    test_wrap_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
